// File: rtl/fft_banked_ram_if.sv
// Dual request port bundle for fft_banked_ram: two independent read/write ports, each with
// en/we/adr/wd request fields, an accept strobe (ready) and a registered read return (rd/rvalid).
`timescale 1ns/1ps
interface fft_banked_ram_if #(
  parameter int width = 16,
  parameter int M     = 9
);
  // Handshake: a request is taken on the clk edge where en && ready; the master must hold
  // en/we/adr/wd stable until that edge, and rd/rvalid answer it exactly one cycle later.
  logic               ena;
  logic               wea;
  logic [M-1:0]       adra;
  logic [2*width-1:0] wda;
  logic [2*width-1:0] rda;
  logic               rvalida;
  logic               readya;
  logic               enb;
  logic               web;
  logic [M-1:0]       adrb;
  logic [2*width-1:0] wdb;
  logic [2*width-1:0] rdb;
  logic               rvalidb;
  logic               readyb;

  modport master (
    output ena, wea, adra, wda, enb, web, adrb, wdb,
    input  rda, rvalida, readya, rdb, rvalidb, readyb
  );

  modport slave (
    input  ena, wea, adra, wda, enb, web, adrb, wdb,
    output rda, rvalida, readya, rdb, rvalidb, readyb
  );
endinterface

// File: rtl/fft_banked_ram.sv
// Two-bank FFT working memory: word address parity picks the bank, so butterfly pairs never collide.
// Optional macro FFT_RAM_WRITE_FIRST_EN: accepted writes return the new data (write-first) instead of the old word.
`timescale 1ns/1ps
module fft_banked_ram #(
  parameter int width = 16,
  parameter int M     = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  output logic                  busy,
  fft_banked_ram_if.slave       bus,
  output logic                  dbg_state,
  output logic [M-2:0]          dbg_sweep_idx
);
  localparam int DW    = 2 * width;
  localparam int IW    = M - 1;
  localparam int DEPTH = 2 ** IW;

`ifdef FFT_RAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rda_q, rda_d, rdb_q, rdb_d;
  logic            rvalida_q, rvalida_d, rvalidb_q, rvalidb_d;

  logic [DW-1:0]   mem_q [2][DEPTH];

  logic            bank_a, bank_b, conflict, acc_a, acc_b;
  logic [1:0]      bank_we;
  logic [IW-1:0]   bank_idx [2];
  logic [DW-1:0]   bank_wd [2];
  logic [DW-1:0]   bank_rd [2];

  assign bank_a   = ^bus.adra;
  assign bank_b   = ^bus.adrb;
  assign busy     = (state_q == CLEAR);
  assign conflict = bus.ena && (bank_a == bank_b);
  // Port A always wins a bank collision; B stalls via readyb until A leaves its bank.
  assign bus.readya = !busy && !reset;
  assign bus.readyb = !busy && !reset && !conflict;
  assign acc_a      = bus.ena && bus.readya;
  assign acc_b      = bus.enb && bus.readyb;

  // Each bank sees exactly one address per cycle: sweep, else port A, else port B.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_we[b]  = 1'b0;
      bank_idx[b] = cnt_q;
      bank_wd[b]  = '0;
      if (busy) begin
        bank_we[b] = 1'b1;
      end else if (acc_a && (bank_a == 1'(b))) begin
        bank_we[b]  = bus.wea;
        bank_idx[b] = bus.adra[M-1:1];
        bank_wd[b]  = bus.wda;
      end else if (acc_b && (bank_b == 1'(b))) begin
        bank_we[b]  = bus.web;
        bank_idx[b] = bus.adrb[M-1:1];
        bank_wd[b]  = bus.wdb;
      end
      bank_rd[b] = mem_q[b][bank_idx[b]];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rda_d     = rda_q;
    rdb_d     = rdb_q;
    rvalida_d = acc_a;
    rvalidb_d = acc_b;
    if (acc_a) rda_d = (WRITE_FIRST && bus.wea) ? bus.wda : bank_rd[bank_a];
    if (acc_b) rdb_d = (WRITE_FIRST && bus.web) ? bus.wdb : bank_rd[bank_b];
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // clr is deliberately ignored here so a running sweep is never restarted.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {IW{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      rda_q     <= '0;
      rdb_q     <= '0;
      rvalida_q <= 1'b0;
      rvalidb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rda_q     <= rda_d;
      rdb_q     <= rdb_d;
      rvalida_q <= rvalida_d;
      rvalidb_q <= rvalidb_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (bank_we[b]) mem_q[b][bank_idx[b]] <= bank_wd[b];
    end
  end

  assign bus.rda       = rda_q;
  assign bus.rdb       = rdb_q;
  assign bus.rvalida   = rvalida_q;
  assign bus.rvalidb   = rvalidb_q;
  assign dbg_state     = state_q;
  assign dbg_sweep_idx = cnt_q;
endmodule

// File: tb/tb_fft_banked_ram.sv
// Bench for fft_banked_ram: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a word-addressed memory model.
`timescale 1ns/1ps
module tb_fft_banked_ram;
  localparam int W    = 16;
  localparam int M    = 9;
  localparam int DW   = 2 * W;
  localparam int N    = 2 ** M;
  localparam int HALF = N / 2;
`ifdef FFT_RAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic busy;
  logic dbg_state;
  logic [M-2:0] dbg_sweep_idx;
  always #5 clk = ~clk;

  fft_banked_ram_if #(.width(W), .M(M)) bus ();

  fft_banked_ram #(.width(W), .M(M)) dut (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy), .bus(bus.slave),
    .dbg_state(dbg_state), .dbg_sweep_idx(dbg_sweep_idx)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit par(input logic [M-1:0] a);
    return ^a;
  endfunction

  // reference model: plain word array, sweep countdown, expected read returns
  logic [DW-1:0] m_mem [N];
  int            m_busy_left = 0;
  bit            m_known = 1'b0;
  logic [DW-1:0] m_rda = '0, m_rdb = '0;
  bit            m_va = 1'b0, m_vb = 1'b0;
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) begin
    bit exp_ra, exp_rb, acc_a, acc_b;
    int c;
    exp_ra = !reset && (m_busy_left == 0);
    exp_rb = exp_ra && !(bus.ena && (par(bus.adra) == par(bus.adrb)));
    if (m_known) begin
      check("busy", busy, m_busy_left > 0);
      check("readya", bus.readya, exp_ra);
      check("readyb", bus.readyb, exp_rb);
      check("rvalida", bus.rvalida, m_va);
      check("rvalidb", bus.rvalidb, m_vb);
      check("rda", bus.rda, m_rda);
      check("rdb", bus.rdb, m_rdb);
    end
    if (reset) begin
      m_known = 1'b1;
      m_busy_left = HALF;
      m_va = 1'b0; m_vb = 1'b0;
      m_rda = '0;  m_rdb = '0;
    end else if (m_known) begin
      if (m_busy_left > 0) begin
        c = HALF - m_busy_left;
        m_mem[2*c] = '0;
        m_mem[2*c+1] = '0;
        m_busy_left--;
        m_va = 1'b0; m_vb = 1'b0;
      end else begin
        acc_a = bus.ena;
        acc_b = bus.enb && exp_rb;
        m_va = acc_a; m_vb = acc_b;
        if (acc_a) begin
          m_rda = (WF && bus.wea) ? bus.wda : m_mem[bus.adra];
          if (bus.wea) m_mem[bus.adra] = bus.wda;
        end
        if (acc_b) begin
          m_rdb = (WF && bus.web) ? bus.wdb : m_mem[bus.adrb];
          if (bus.web) m_mem[bus.adrb] = bus.wdb;
        end
        if (clr) m_busy_left = HALF;
      end
    end
  end

  // driver tasks: all start and end at posedge+1
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.ena = 1'b0; bus.wea = 1'b0; bus.enb = 1'b0; bus.web = 1'b0; clr = 1'b0;
  endtask

  task automatic req_a(input logic we, input logic [M-1:0] adr, input logic [DW-1:0] wd);
    bus.ena = 1'b1; bus.wea = we; bus.adra = adr; bus.wda = wd;
  endtask

  task automatic req_b(input logic we, input logic [M-1:0] adr, input logic [DW-1:0] wd);
    bus.enb = 1'b1; bus.web = we; bus.adrb = adr; bus.wdb = wd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("reset_readya", bus.readya, 1'b0);
    check("reset_readyb", bus.readyb, 1'b0);
    next_cycle();
    reset = 1'b0;
    check("reset_busy", busy, 1'b1);
    check("reset_rda", bus.rda, '0);
    check("reset_rdb", bus.rdb, '0);
    check("reset_rvalida", bus.rvalida, 1'b0);
    check("reset_rvalidb", bus.rvalidb, 1'b0);
    check("reset_sweep_idx", dbg_sweep_idx, '0);
  endtask

  task automatic count_busy(input int clr_at, output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == clr_at) clr = 1'b1;
      @(negedge clk);
      if (!busy) break;
      n++;
      next_cycle();
      clr = 1'b0;
    end
    next_cycle();
    clr = 1'b0;
  endtask

  // read one address on port A and queue the literal expected value for the scoreboard
  task automatic read_a_expect(input logic [M-1:0] adr, input logic [DW-1:0] exp, input string name);
    logic [DW-1:0] e;
    exp_q.push_back(exp);
    req_a(1'b0, adr, '0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, bus.rda, e);
    check({name, "_valid"}, bus.rvalida, 1'b1);
    next_cycle();
  endtask

  function automatic logic [M-1:0] rand_adr();
    if ($urandom_range(0, 1) == 1) return M'($urandom_range(0, 15));
    return M'($urandom_range(0, N - 1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int n;
    bit b_hold;
    idle_inputs();
    bus.adra = '0; bus.wda = '0; bus.adrb = '0; bus.wdb = '0;
    repeat (3) next_cycle();

    // power-up sweep length, then memory reads as zero
    do_reset();
    count_busy(-1, n);
    check("busy_len", n, HALF);
    read_a_expect(9'd77, 32'h0, "read_after_sweep");

    // opposite-bank writes in one cycle
    req_a(1'b1, 9'd5, 32'h0001_0002);
    req_b(1'b1, 9'd4, 32'h0003_0004);
    @(negedge clk);
    check("wr_pair_readya", bus.readya, 1'b1);
    check("wr_pair_readyb", bus.readyb, 1'b1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("wr_pair_rvalida", bus.rvalida, 1'b1);
    check("wr_pair_rvalidb", bus.rvalidb, 1'b1);
    next_cycle();
    req_a(1'b0, 9'd4, '0);
    req_b(1'b0, 9'd5, '0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rd_pair_rda", bus.rda, 32'h0003_0004);
    check("rd_pair_rdb", bus.rdb, 32'h0001_0002);
    next_cycle();

    // same-bank reads: B stalls one cycle
    req_a(1'b0, 9'd3, '0);
    req_b(1'b0, 9'd5, '0);
    @(negedge clk);
    check("conf_readyb_low", bus.readyb, 1'b0);
    next_cycle();
    bus.ena = 1'b0;
    @(negedge clk);
    check("conf_rvalida_t1", bus.rvalida, 1'b1);
    check("conf_rda_t1", bus.rda, 32'h0);
    check("conf_rvalidb_t1", bus.rvalidb, 1'b0);
    check("conf_readyb_t1", bus.readyb, 1'b1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("conf_rvalidb_t2", bus.rvalidb, 1'b1);
    check("conf_rdb_t2", bus.rdb, 32'h0001_0002);
    next_cycle();

    // both ports write address 7: A first, B last
    req_a(1'b1, 9'd7, 32'hAAAA_AAAA);
    req_b(1'b1, 9'd7, 32'hBBBB_BBBB);
    @(negedge clk);
    check("same_adr_readyb", bus.readyb, 1'b0);
    next_cycle();
    bus.ena = 1'b0;
    next_cycle();
    idle_inputs();
    read_a_expect(9'd7, 32'hBBBB_BBBB, "same_adr_final");

    // read-first vs write-first return on overwrite
    req_a(1'b1, 9'd10, 32'hFFFF_0000);
    next_cycle();
    req_a(1'b1, 9'd10, 32'h1234_5678);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("overwrite_return", bus.rda, WF ? 32'h1234_5678 : 32'hFFFF_0000);
    next_cycle();
    read_a_expect(9'd10, 32'h1234_5678, "overwrite_readback");

    // randomized traffic; B holds any request that was not accepted
    b_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.ena  = ($urandom_range(0, 3) != 0);
      bus.wea  = 1'($urandom_range(0, 1));
      bus.adra = rand_adr();
      bus.wda  = $urandom;
      if (!b_hold) begin
        bus.enb  = ($urandom_range(0, 3) != 0);
        bus.web  = 1'($urandom_range(0, 1));
        bus.adrb = rand_adr();
        bus.wdb  = $urandom;
      end
      clr   = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
      b_hold = bus.enb && !bus.readyb && !reset;
      next_cycle();
    end
    reset = 1'b0;
    idle_inputs();
    next_cycle();

    // reset mid-sweep restarts it; clr during the sweep is ignored
    do_reset();
    for (int i = 0; i < 400 && dbg_sweep_idx != 9'd100; i++) next_cycle();
    check("reached_idx_100", dbg_sweep_idx, 100);
    do_reset();
    count_busy(20, n);
    check("busy_len_restart", n, HALF);
    read_a_expect(9'd7, 32'h0, "read_after_restart");
    read_a_expect(9'd10, 32'h0, "read10_after_restart");

    repeat (2) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fft_banked_ram.md
FFT_BANKED_RAM -- requirements
Module: fft_banked_ram

Interface
REQ-001 Parameter: width, default 16, half-word width; stored word is 2*width bits (real/imag pair).
REQ-002 Parameter: M, default 9, address bits; total depth 2**M words.
REQ-003 Port: clk  input  1  single clock for all logic; no second clock, no phase multiplexing.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: clr  input  1  single-cycle pulse, request zero-sweep of whole memory.
REQ-006 Port: busy  output  1  high while zero-sweep in progress.
REQ-007 Port: ena, wea  input  1 each  port A request enable / write enable.
REQ-008 Port: adra  input  M  port A word address; wda  input  2*width  write data; rda  output  2*width  read data; rvalida  output  1  read data valid.
REQ-009 Port: enb, web, adrb, wdb, rdb, rvalidb  same widths and meaning as port A, for port B.
REQ-010 Port: readya, readyb  output  1 each  request accepted this cycle when en && ready.

Function
REQ-011 Storage SHALL be two single-port banks of 2**(M-1) words; bank = XOR-reduction (parity) of address; bank-local index = address[M-1:1].
REQ-012 Radix-2 butterfly address pairs (differ in exactly one bit) SHALL always map to opposite banks and complete in one cycle.
REQ-013 readya = !busy; readyb = !busy && !(ena && bank(adra)==bank(adrb)) (combinational).
REQ-014 Bank conflict: port A wins; port B SHALL hold its request and is accepted the next cycle A does not conflict.
REQ-015 Accepted request with we=1 writes wd to addressed word at the clk edge; with we=0 memory unchanged.
REQ-016 Read latency 1: rd* updates and rvalid* pulses high one cycle after every accepted request (read or write); rd* holds last value otherwise.
REQ-017 Same address written by both ports: conflict rule serialises A then B; final content = wdb.
REQ-018 FSM states IDLE, CLEAR: IDLE->CLEAR on clr or reset; CLEAR->IDLE after index 2**(M-1)-1 written in both banks.
REQ-019 CLEAR writes zero to both banks at counter index, counter 0..2**(M-1)-1 one step per cycle; busy=1 for exactly 2**(M-1) cycles.
REQ-020 Requests presented while busy SHALL be ignored (ready low), no memory change, no rvalid.
REQ-021 clr while already in CLEAR SHALL be ignored (sweep not restarted).

Reset
REQ-022 reset SHALL force: state CLEAR, counter 0, busy 1, rda/rdb 0, rvalida/rvalidb 0, readya/readyb 0.
REQ-023 reset asserted mid-sweep or mid-conflict SHALL restart the sweep from index 0 and drop any pending port B request.
REQ-024 No initial blocks; zeroed memory after power-up is guaranteed only by the reset-triggered sweep.

Configuration
REQ-025 Macro FFT_RAM_WRITE_FIRST_EN: defined -> an accepted write returns the new wd on rd* next cycle (write-first); undefined -> returns the previous stored word (read-first).

Verification
REQ-026 M=9: reset 1 cycle -> busy high exactly 256 cycles, then readya=1; read any address -> rda=0.
REQ-027 A writes 0x0001_0002 to 5, B writes 0x0003_0004 to 4 same cycle -> both ready, both rvalid next cycle; reads return those values.
REQ-028 A reads 3, B reads 5 (same bank) -> readyb=0 that cycle, B accepted next cycle; rvalida at T+1, rvalidb at T+2.
REQ-029 Both write address 7 (A=0xAAAA_AAAA, B=0xBBBB_BBBB) -> readback of 7 = 0xBBBB_BBBB.
REQ-030 Write 0x1234_5678 to 10 over old 0xFFFF_0000 -> rda next cycle = 0x1234_5678 with macro, 0xFFFF_0000 without.
REQ-031 Assert reset at sweep index 100, then clr during CLEAR -> sweep restarts, busy lasts 256 cycles from reset, clr ignored.
